// File: rtl/systolic_wload_sequencer.sv
// systolic_wload_sequencer: streams row-wide weight words into the PE array
// rows through a valid/ready handshake. Each accepted word is steered to one
// row via a one-hot write enable. That enable is decoded from an internal row
// counter by onehot_encoder. A single-cycle done pulse marks the end of a preload.
// Optional build macro: WLOAD_REVERSE_EN (bottom-up row order).

module onehot_encoder #(
    parameter int AWidth = 4
) (
    input  logic [AWidth-1:0]    idx_i,
    output logic [2**AWidth-1:0] onehot_o
);
    localparam int NumRows = 2**AWidth;

    // Decode a row index into a single set bit
    always_comb begin
        onehot_o        = {NumRows{1'b0}};
        onehot_o[idx_i] = 1'b1;
    end
endmodule

module systolic_wload_sequencer #(
    parameter int AWidth = 4,
    parameter int DWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AWidth:0]      num_rows_i,
    input  logic [DWidth-1:0]    wdata_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [2**AWidth-1:0] row_we_o,
    output logic [DWidth-1:0]    row_data_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int NumRows = 2**AWidth;
    localparam logic [AWidth:0]   RowsMax = (AWidth+1)'(NumRows);
    localparam logic [AWidth:0]   RemOne  = (AWidth+1)'(1);
    localparam logic [AWidth:0]   RemZero = (AWidth+1)'(0);
    localparam logic [AWidth-1:0] CntOne  = AWidth'(1);
    localparam logic [AWidth-1:0] CntZero = AWidth'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_r, state_s;
    logic [AWidth-1:0]     row_cnt_r, row_cnt_s;
    logic [AWidth:0]       rem_r, rem_s;
    logic [NumRows-1:0]    row_we_r;
    logic [DWidth-1:0]     row_data_r;
    logic [AWidth:0]       n_clamp_s;
    logic [AWidth:0]       n_minus1_s;
    logic [AWidth-1:0]     cnt_init_s;
    logic [NumRows-1:0]    onehot_s;
    logic                  hs_s;

    // Clamp the requested row count to the physical array height
    always_comb begin
        if (num_rows_i > RowsMax) begin
            n_clamp_s = RowsMax;
        end else begin
            n_clamp_s = num_rows_i;
        end
        n_minus1_s = n_clamp_s - RemOne;
    end

`ifdef WLOAD_REVERSE_EN
    // Bottom-up: counter starts at the last row and walks toward row 0
    always_comb begin
        cnt_init_s = n_minus1_s[AWidth-1:0];
    end
`else
    // Top-down: counter starts at row 0
    always_comb begin
        cnt_init_s = CntZero;
    end
`endif

    assign hs_s = valid_i & (state_r == ST_LOAD);

    onehot_encoder #(.AWidth(AWidth)) u_onehot (
        .idx_i    (row_cnt_r),
        .onehot_o (onehot_s)
    );

    // Next-state, row counter and remaining-count logic
    always_comb begin
        state_s   = state_r;
        row_cnt_s = row_cnt_r;
        rem_s     = rem_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    rem_s     = n_clamp_s;
                    row_cnt_s = cnt_init_s;
                    if (n_clamp_s == RemZero) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    rem_s = rem_r - RemOne;
`ifdef WLOAD_REVERSE_EN
                    row_cnt_s = row_cnt_r - CntOne;
`else
                    row_cnt_s = row_cnt_r + CntOne;
`endif
                    if (rem_r == RemOne) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and remaining-count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            row_cnt_r <= CntZero;
            rem_r     <= RemZero;
        end else begin
            state_r   <= state_s;
            row_cnt_r <= row_cnt_s;
            rem_r     <= rem_s;
        end
    end

    // Register the row write: one cycle after each accepted word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_we_r   <= {NumRows{1'b0}};
            row_data_r <= {DWidth{1'b0}};
        end else if (hs_s) begin
            row_we_r   <= onehot_s;
            row_data_r <= wdata_i;
        end else begin
            row_we_r   <= {NumRows{1'b0}};
            row_data_r <= row_data_r;
        end
    end

    assign ready_o    = (state_r == ST_LOAD);
    assign busy_o     = (state_r != ST_IDLE);
    assign done_o     = (state_r == ST_DONE);
    assign row_we_o   = row_we_r;
    assign row_data_o = row_data_r;
endmodule

// File: tb/tb_systolic_wload_sequencer.sv
// Scoreboard bench for systolic_wload_sequencer (AWidth=4, DWidth=128).
// Expected row writes are queued as words are issued; a monitor pops and
// compares whenever the DUT shows a row write or a done pulse.

module tb_systolic_wload_sequencer;
    logic         clk_i;
    logic         rst_ni;
    logic         start_i;
    logic [4:0]   num_rows_i;
    logic [127:0] wdata_i;
    logic         valid_i;
    logic         ready_o;
    logic [15:0]  row_we_o;
    logic [127:0] row_data_o;
    logic         busy_o;
    logic         done_o;

    typedef struct {
        logic [15:0]  we;
        logic [127:0] data;
        logic         done;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;

    systolic_wload_sequencer #(.AWidth(4), .DWidth(128)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .num_rows_i (num_rows_i),
        .wdata_i    (wdata_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .row_we_o   (row_we_o),
        .row_data_o (row_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every row write or done pulse must match the head of the queue
    always begin
        exp_t e;
        @(posedge clk_i);
        #1;
        if (rst_ni === 1'b1 && (row_we_o !== 16'h0000 || done_o !== 1'b0)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got we=%h done=%b expected nothing at %0t",
                         row_we_o, done_o, $time);
            end else begin
                e = q.pop_front();
                chk("row_we", {112'd0, row_we_o}, {112'd0, e.we});
                chk("done", {127'd0, done_o}, {127'd0, e.done});
                chk("busy_on_out", {127'd0, busy_o}, 128'd1);
                if (e.we != 16'h0000) begin
                    chk("row_data", row_data_o, e.data);
                end
            end
        end
    end

    function automatic logic [127:0] word(input int t, input int k);
        logic [31:0] v;
        v = 32'hA5000000 + (32'(t) << 8) + 32'(k);
        return {v, ~v, v ^ 32'h5A5A5A5A, v + 32'h11111111};
    endfunction

    task automatic start(input logic [4:0] n);
        exp_t e;
        @(negedge clk_i);
        chk("busy_before_start", {127'd0, busy_o}, 128'd0);
        start_i    = 1'b1;
        num_rows_i = n;
        if (n == 5'd0) begin
            e.we = 16'h0000; e.data = 128'd0; e.done = 1'b1;
            q.push_back(e);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", {127'd0, busy_o}, 128'd1);
    endtask

    // Issue one word; k is the word number, n the clamped row count
    task automatic send(input logic [127:0] w, input int k, input int n);
        exp_t e;
        int   row;
`ifdef WLOAD_REVERSE_EN
        row = n - 1 - k;
`else
        row = k;
`endif
        @(negedge clk_i);
        valid_i = 1'b1;
        wdata_i = w;
        chk("ready_in_load", {127'd0, ready_o}, 128'd1);
        e.we   = 16'h0001 << row;
        e.data = w;
        e.done = (k == n - 1);
        q.push_back(e);
    endtask

    task automatic idle(input int k);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (k - 1) @(negedge clk_i);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_ni = 1'b0; start_i = 1'b0; num_rows_i = 5'd0;
        wdata_i = 128'd0; valid_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_ready", {127'd0, ready_o}, 128'd0);
        chk("rst_we", {112'd0, row_we_o}, 128'd0);
        chk("rst_data", row_data_o, 128'd0);
        chk("rst_busy", {127'd0, busy_o}, 128'd0);
        chk("rst_done", {127'd0, done_o}, 128'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_ready", {127'd0, ready_o}, 128'd0);

        // Basic load of three rows, back to back
        start(5'd3);
        for (int k = 0; k < 3; k++) send(word(1, k), k, 3);
        @(negedge clk_i);
        valid_i = 1'b0;
        chk("basic_done", {127'd0, done_o}, 128'd1);
        chk("basic_ready_off", {127'd0, ready_o}, 128'd0);
        @(negedge clk_i);
        chk("basic_busy_fall", {127'd0, busy_o}, 128'd0);
        chk("basic_q_empty", 128'(q.size()), 128'd0);

        // Stall: valid 1,0,0,1
        start(5'd2);
        send(word(2, 0), 0, 2);
        idle(2);
        send(word(2, 1), 1, 2);
        idle(3);
        chk("stall_busy", {127'd0, busy_o}, 128'd0);
        chk("stall_q_empty", 128'(q.size()), 128'd0);

        // Zero rows: done one cycle after start, no writes
        start(5'd0);
        idle(3);
        chk("zero_busy", {127'd0, busy_o}, 128'd0);
        chk("zero_q_empty", 128'(q.size()), 128'd0);

        // Clamp: 20 requested, 16 written
        start(5'd20);
        for (int k = 0; k < 16; k++) send(word(3, k), k, 16);
        idle(4);
        chk("clamp_busy", {127'd0, busy_o}, 128'd0);
        chk("clamp_q_empty", 128'(q.size()), 128'd0);

        // Start while busy is ignored; then async reset mid-preload
        start(5'd5);
        send(word(4, 0), 0, 5);
        @(negedge clk_i);
        valid_i    = 1'b0;
        start_i    = 1'b1;
        num_rows_i = 5'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("ign_start_busy", {127'd0, busy_o}, 128'd1);
        chk("ign_start_ready", {127'd0, ready_o}, 128'd1);
        send(word(4, 1), 1, 5);
        @(negedge clk_i);
        valid_i = 1'b0;
        chk("pre_rst_q_empty", 128'(q.size()), 128'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_we", {112'd0, row_we_o}, 128'd0);
        chk("arst_data", row_data_o, 128'd0);
        chk("arst_ready", {127'd0, ready_o}, 128'd0);
        chk("arst_busy", {127'd0, busy_o}, 128'd0);
        chk("arst_done", {127'd0, done_o}, 128'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("post_rst_busy", {127'd0, busy_o}, 128'd0);
        chk("final_q_empty", 128'(q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
